// File: rtl/misao_mem_pkg.sv
// Shared types and constants for the misao boot-loaded memory responder.
// Holds the CLEAR/LOAD/RUN state encoding, the CPU address width and the default geometry.
package misao_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam int CPU_ADDR_W = 15;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/misao_mem_array.sv
// Byte storage for the memory responder.
// It has one synchronous write port and one asynchronous read port, and its cells have no reset.
module misao_mem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/misao_mem_resp.sv
// This module zero-fills its memory, loads a boot image from a byte stream, and then serves CPU reads and writes.
// Defining MISAO_MEM_WPROT_EN makes RUN-mode writes below WP_LIMIT read-only and adds a wp_err flag.
module misao_mem_resp
    import misao_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
`ifdef MISAO_MEM_WPROT_EN
    , parameter int WP_LIMIT = 'h40
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_enable_read,
    input  logic                  mem_enable_write,
    input  logic [CPU_ADDR_W-1:0] mem_addr,
    input  logic                  mem_rw,
    input  logic [7:0]            mem_data_out,
    output logic [7:0]            mem_data_in,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst,
    output logic [ADDR_W:0]       load_count,
    output logic                  oob_err,
`ifdef MISAO_MEM_WPROT_EN
    output logic                  wp_err,
`endif
    output state_e                dbg_state_o
);

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic [ADDR_W:0]   load_count_q;
    logic              cpu_rst_q;
    logic              ld_ready_q;
    logic              oob_err_q;

    logic              in_range;
    logic              wp_hit;
    logic              ld_fire;
    logic              ld_done;
    logic              cpu_we;
    logic              arr_we_d;
    logic [ADDR_W-1:0] arr_waddr_d;
    logic [7:0]        arr_wdata_d;
    logic [7:0]        arr_rdata;

    // The loader/CPU handshake works like this. A loader byte moves on a rising edge where ld_valid and ld_ready are both high.
    // ld_ready is high only in LOAD. The CPU strobes have no backpressure, so an access is always zero-wait.
    assign in_range = 32'(mem_addr) < 32'(DEPTH);
    assign ld_fire  = ld_valid && ld_ready_q;
    assign ld_done  = ld_last || (load_count_q[ADDR_W-1:0] == ADDR_W'(DEPTH - 1));

`ifdef MISAO_MEM_WPROT_EN
    logic wp_err_q;
    assign wp_hit = 32'(mem_addr) < 32'(WP_LIMIT);
    assign wp_err = wp_err_q;
`else
    assign wp_hit = 1'b0;
`endif

    assign cpu_we = (state_q == RUN) && mem_enable_write && in_range && !wp_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            load_count_q <= '0;
            cpu_rst_q    <= 1'b1;
            ld_ready_q   <= 1'b0;
            oob_err_q    <= 1'b0;
`ifdef MISAO_MEM_WPROT_EN
            wp_err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q    <= LOAD;
                        ld_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ld_fire) begin
                        load_count_q <= load_count_q + (ADDR_W + 1)'(1);
                        if (ld_done) begin
                            state_q    <= RUN;
                            ld_ready_q <= 1'b0;
                            cpu_rst_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if ((mem_enable_read || mem_enable_write) && !in_range) begin
                        oob_err_q <= 1'b1;
                    end
`ifdef MISAO_MEM_WPROT_EN
                    if (mem_enable_write && in_range && wp_hit) begin
                        wp_err_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // The state decides which source owns the single write port: the clear counter, the loader, or the CPU.
    always_comb begin
        arr_we_d    = 1'b0;
        arr_waddr_d = '0;
        arr_wdata_d = 8'h00;
        case (state_q)
            CLEAR: begin
                arr_we_d    = 1'b1;
                arr_waddr_d = clr_addr_q;
            end
            LOAD: begin
                arr_we_d    = ld_fire;
                arr_waddr_d = load_count_q[ADDR_W-1:0];
                arr_wdata_d = ld_data;
            end
            RUN: begin
                arr_we_d    = cpu_we;
                arr_waddr_d = mem_addr[ADDR_W-1:0];
                arr_wdata_d = mem_data_out;
            end
            default: ;
        endcase
    end

    misao_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (arr_we_d),
        .waddr_i (arr_waddr_d),
        .wdata_i (arr_wdata_d),
        .raddr_i (mem_addr[ADDR_W-1:0]),
        .rdata_o (arr_rdata)
    );

    assign mem_data_in = ((state_q == RUN) && mem_enable_read && in_range) ? arr_rdata : 8'h00;
    assign ld_ready    = ld_ready_q;
    assign cpu_rst     = cpu_rst_q;
    assign load_count  = load_count_q;
    assign oob_err     = oob_err_q;
    assign dbg_state_o = state_q;

    // The direction hint is not used to qualify accesses; only the strobes count.
    logic unused_ok;
    assign unused_ok = mem_rw;

endmodule

// File: tb/tb_misao_mem_resp.sv
// Directed self-checking bench for misao_mem_resp.
// It covers the clear timing, short and full-depth loads, RUN accesses, out-of-range handling and reset restarts.
module tb_misao_mem_resp;
    import misao_mem_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic        clk;
    logic        rst;
    logic        mem_enable_read;
    logic        mem_enable_write;
    logic [14:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_rst;
    logic [ADDR_W:0] load_count;
    logic        oob_err;
`ifdef MISAO_MEM_WPROT_EN
    logic        wp_err;
`endif
    state_e      dbg_state;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q[$];
    int          clr_cycles;

    misao_mem_resp #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_addr         (mem_addr),
        .mem_rw           (mem_rw),
        .mem_data_out     (mem_data_out),
        .mem_data_in      (mem_data_in),
        .ld_valid         (ld_valid),
        .ld_data          (ld_data),
        .ld_last          (ld_last),
        .ld_ready         (ld_ready),
        .cpu_rst          (cpu_rst),
        .load_count       (load_count),
        .oob_err          (oob_err),
`ifdef MISAO_MEM_WPROT_EN
        .wp_err           (wp_err),
`endif
        .dbg_state_o      (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks. Each one starts at a negedge and returns at a negedge.
    task automatic cpu_idle();
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_addr         = '0;
        mem_data_out     = 8'h00;
    endtask

    task automatic wait_clear(output int cycles);
        cycles = 0;
        while (!ld_ready && cycles < 400) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
        mem_enable_write = 1'b1;
        mem_addr         = a;
        mem_data_out     = d;
        @(posedge clk);
        @(negedge clk);
        mem_enable_write = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [14:0] a, input logic [7:0] exp);
        mem_enable_read = 1'b1;
        mem_addr        = a;
        #1;
        check(tag, mem_data_in, exp);
        mem_enable_read = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        mem_rw   = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        ld_last  = 1'b0;
        cpu_idle();
        mem_enable_read = 1'b1;
        mem_addr        = 15'h0001;

        // Check the values held while reset is asserted.
        #2;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_load_count", load_count, 0);
        check("rst_oob_err", oob_err, 0);
        check("rst_data_in", mem_data_in, 8'h00);
        check("rst_state", dbg_state, CLEAR);
        cpu_idle();

        // CLEAR must last exactly DEPTH cycles.
        @(negedge clk);
        rst = 1'b0;
        wait_clear(clr_cycles);
        check("clear_cycles", clr_cycles, 256);
        check("load_cpu_rst", cpu_rst, 1);

        // Load a short image that ends with ld_last.
        load_byte(8'h00, 1'b0);
        load_byte(8'h4E, 1'b0);
        check("load2_count", load_count, 2);
        check("load2_cpu_rst", cpu_rst, 1);
        load_byte(8'h1A, 1'b1);
        check("load3_count", load_count, 3);
        check("load3_cpu_rst", cpu_rst, 0);
        check("load3_ld_ready", ld_ready, 0);
        check("load3_state", dbg_state, RUN);
        cpu_read_check("rd_0001", 15'h0001, 8'h4E);
        cpu_read_check("rd_0002", 15'h0002, 8'h1A);
        mem_addr = 15'h0001;
        #1;
        check("rd_disabled", mem_data_in, 8'h00);
        @(negedge clk);

        // A write followed by a read-back; a read in the same cycle as the write sees the old value.
        mem_enable_write = 1'b1;
        mem_enable_read  = 1'b1;
        mem_addr         = 15'h0081;
        mem_data_out     = 8'h5B;
        #1;
        check("wr_rd_same_old", mem_data_in, 8'h00);
        @(posedge clk);
        @(negedge clk);
        cpu_idle();
        cpu_read_check("rd_0081", 15'h0081, 8'h5B);

        // An out-of-range write is dropped and sets oob_err.
        check("oob_before", oob_err, 0);
        cpu_write(15'h0100, 8'hAA);
        check("oob_set", oob_err, 1);
        cpu_read_check("oob_cell0", 15'h0000, 8'h00);
        cpu_read_check("oob_rd_0100", 15'h0100, 8'h00);
        repeat (4) @(negedge clk);
        check("oob_sticky", oob_err, 1);

        // Reset from RUN, then stream a full-depth image with no ld_last.
        reset_pulse();
        check("rerst_oob_clr", oob_err, 0);
        wait_clear(clr_cycles);
        check("clear_cycles2", clr_cycles, 256);
        mem_enable_read  = 1'b1;
        mem_enable_write = 1'b1;
        mem_addr         = 15'h0200;
        mem_data_out     = 8'hEE;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) cpu_idle();
            ld_valid = 1'b1;
            ld_data  = 8'(i) ^ 8'h5A;
            exp_q.push_back(8'(i) ^ 8'h5A);
            @(posedge clk);
            @(negedge clk);
            if (i == 127) begin
                check("load_rd_zero", mem_data_in, 8'h00);
                check("load_oob_ignored", oob_err, 0);
            end
            if (i == 254) check("cpu_rst_before_last", cpu_rst, 1);
        end
        ld_valid = 1'b0;
        check("full_count", load_count, 256);
        check("full_ld_ready", ld_ready, 0);
        check("full_cpu_rst", cpu_rst, 0);
        check("full_state", dbg_state, RUN);
        for (int a = 0; a < 256; a++) begin
            cpu_read_check("full_readback", 15'(a), exp_q.pop_front());
        end
        check("full_oob_clean", oob_err, 0);
        @(negedge clk);

        // Reset in the middle of CLEAR, then in the middle of LOAD, then reload a single byte.
        reset_pulse();
        repeat (10) @(negedge clk);
        reset_pulse();
        wait_clear(clr_cycles);
        check("clear_cycles3", clr_cycles, 256);
        for (int i = 0; i < 5; i++) load_byte(8'h11 + 8'(i), 1'b0);
        check("mid_load_count", load_count, 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_count", load_count, 0);
        check("midrst_ld_ready", ld_ready, 0);
        check("midrst_cpu_rst", cpu_rst, 1);
        check("midrst_state", dbg_state, CLEAR);
        @(negedge clk);
        rst = 1'b0;
        wait_clear(clr_cycles);
        check("clear_cycles4", clr_cycles, 256);
        load_byte(8'h77, 1'b1);
        check("reload_cpu_rst", cpu_rst, 0);
        cpu_read_check("reload_addr0", 15'h0000, 8'h77);
        cpu_read_check("reload_addr3", 15'h0003, 8'h00);
        cpu_read_check("reload_addr2", 15'h0002, 8'h00);

`ifdef MISAO_MEM_WPROT_EN
        check("wp_before", wp_err, 0);
        cpu_write(15'h0010, 8'h99);
        check("wp_set", wp_err, 1);
        cpu_read_check("wp_rd_0010", 15'h0010, 8'h00);
        cpu_write(15'h0050, 8'h42);
        cpu_read_check("wp_rd_0050", 15'h0050, 8'h42);
`else
        cpu_write(15'h0010, 8'h99);
        cpu_read_check("nowp_rd_0010", 15'h0010, 8'h99);
`endif

        // An out-of-range read on its own also sets oob_err.
        check("rdoob_before", oob_err, 0);
        cpu_read_check("rdoob_data", 15'h7FFF, 8'h00);
        mem_enable_read = 1'b1;
        mem_addr        = 15'h7FFF;
        @(posedge clk);
        @(negedge clk);
        cpu_idle();
        check("rdoob_set", oob_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/misao_mem_resp.md
MISAO_MEM_RESP -- requirements
Module: misao_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of byte cells (power of two).
REQ-002 SHALL have parameter ADDR_W, default 8, log2(DEPTH).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mem_enable_read  input  1  CPU read strobe.
REQ-007 mem_enable_write  input  1  CPU write strobe.
REQ-008 mem_addr  input  15  CPU byte address.
REQ-009 mem_rw  input  1  CPU direction hint; ignored for qualification.
REQ-010 mem_data_out  input  8  CPU write data.
REQ-011 mem_data_in  output  8  read data to CPU.
REQ-012 ld_valid  input  1  loader byte valid.
REQ-013 ld_data  input  8  loader byte.
REQ-014 ld_last  input  1  final loader byte marker.
REQ-015 ld_ready  output  1  loader byte accepted when ld_valid&&ld_ready at clk edge.
REQ-016 cpu_rst  output  1  holds the CPU in reset until the image is loaded.
REQ-017 load_count  output  ADDR_W+1  bytes accepted in current load.
REQ-018 oob_err  output  1  sticky flag for an access with mem_addr >= DEPTH.

Function
REQ-019 SHALL implement FSM CLEAR -> LOAD -> RUN; RUN is left only through rst.
- CLEAR: writes 0x00 to one cell per cycle, addresses 0..DEPTH-1, then moves to LOAD (DEPTH cycles total).
- LOAD: ld_ready=1; each accepted byte is written at address load_count, which then increments.
REQ-020 SHALL leave LOAD for RUN on the edge that accepts a byte with ld_last=1, or the byte at address DEPTH-1, whichever comes first; there is no wrap.
REQ-021 SHALL hold cpu_rst=1 in CLEAR and LOAD, and drive cpu_rst=0 from the first cycle in RUN.
REQ-022 SHALL in RUN drive mem_data_in combinationally = cell[mem_addr[ADDR_W-1:0]] when mem_enable_read=1 and mem_addr<DEPTH, else 0x00.
REQ-023 SHALL in RUN write mem_data_out to the addressed cell on the clk edge when mem_enable_write=1 and mem_addr<DEPTH.
- Zero-wait-state write.
- A same-cycle read of that cell returns the old value.
REQ-024 SHALL ignore all CPU strobes outside RUN and drive mem_data_in=0x00 outside RUN.
REQ-025 SHALL in RUN, when a strobe occurs with mem_addr>=DEPTH: suppress the write, return 0x00 on read, set oob_err=1 until rst.
REQ-026 SHALL honour read and write strobes asserted together as independent operations.

Reset
REQ-027 SHALL on rst assertion immediately set: state=CLEAR, cpu_rst=1, ld_ready=0, load_count=0, oob_err=0, mem_data_in=0x00.
REQ-028 SHALL, when rst is asserted mid-CLEAR, mid-LOAD or in RUN, restart CLEAR after release, so that all previously loaded or written contents read 0x00 until reloaded.

Configuration
REQ-029 SHALL, with macro MISAO_MEM_WPROT_EN defined, provide parameter WP_LIMIT (default 0x40) and output wp_err (1 bit, sticky) with this behaviour:
- RUN writes to address < WP_LIMIT are suppressed and set wp_err.
- LOAD and CLEAR writes are unaffected.
REQ-030 SHALL, without MISAO_MEM_WPROT_EN, omit wp_err and WP_LIMIT and allow all in-range RUN writes.

Structure
REQ-031 SHALL take from shared package misao_mem_pkg: the state enum (CLEAR, LOAD, RUN), CPU_ADDR_W=15, the default DEPTH/ADDR_W constants.
REQ-032 SHALL place storage in sub-module misao_mem_array: one synchronous write port, one asynchronous read port.
REQ-033 SHALL multiplex the write port among CLEAR counter, loader and CPU according to state.

Verification
REQ-034 Release rst: cpu_rst=1 and ld_ready=0 for exactly 256 cycles, then ld_ready=1.
REQ-035 Load 0x00,0x4E,0x1A with ld_last on the third: load_count=3; cpu_rst=0 next cycle; read addr 0x0001 returns 0x4E; read with enable low returns 0x00.
REQ-036 RUN: write 0x5B to 0x0081, then read 0x0081 returns 0x5B; read in the same cycle as the write returns the prior 0x00.
REQ-037 RUN: write 0xAA to 0x0100: cell 0x00 unchanged, oob_err=1; read 0x0100 returns 0x00; oob_err persists until rst.
REQ-038 Stream 256 bytes without ld_last: RUN entered after the 256th byte, load_count=256, ld_ready=0.
REQ-039 Assert rst after 5 of 10 loaded bytes: outputs reset immediately; after reload of 1 byte, addr 0x0003 reads 0x00; with MISAO_MEM_WPROT_EN, RUN write to 0x0010 is suppressed and wp_err=1.
